// File: rtl/dt_pkg.sv
// dt_pkg: shared definitions for the decision-tree inference engine.
//   - dt_state_e : FSM state encoding (also visible on state_dbg)
//   - DT_ERR_*   : error codes reported on out_err
//   - dt_node_t  : node record at the default engine widths, for tools and
//                  models that hold a whole node table
package dt_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_WAIT   = 3'd2,
    ST_EVAL   = 3'd3,
    ST_RESULT = 3'd4
  } dt_state_e;

  localparam logic [1:0] DT_ERR_NONE    = 2'd0;
  localparam logic [1:0] DT_ERR_DEPTH   = 2'd1;
  localparam logic [1:0] DT_ERR_FIDX    = 2'd2;
  localparam logic [1:0] DT_ERR_TIMEOUT = 2'd3;

  localparam int DT_DEF_FIDX_W  = 2;
  localparam int DT_DEF_FEAT_W  = 64;
  localparam int DT_DEF_ADDR_W  = 9;
  localparam int DT_DEF_CLASS_W = 2;

  typedef struct packed {
    logic [DT_DEF_FIDX_W-1:0]  fidx;
    logic [DT_DEF_FEAT_W-1:0]  threshold;
    logic [DT_DEF_ADDR_W-1:0]  left;
    logic [DT_DEF_ADDR_W-1:0]  right;
    logic [DT_DEF_CLASS_W-1:0] prediction;
    logic                      is_leaf;
  } dt_node_t;

endpackage

// File: rtl/dt_signed_le_cmp.sv
// dt_signed_le_cmp: combinational signed a <= b over W bits.
//   a_i  : left operand (two's complement)
//   b_i  : right operand (two's complement)
//   le_o : 1 when a_i <= b_i
module dt_signed_le_cmp #(
  parameter int W = 64
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         le_o
);

  assign le_o = ($signed(a_i) <= $signed(b_i));

endmodule

// File: rtl/dt_engine_param.sv
// dt_engine_param: decision-tree inference engine for the CAN-bus intrusion
// detector. Takes one feature vector, walks the node table in external memory
// from node 0 and reports the leaf class or an error.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   in_valid/in_ready    feature vector handshake (in_ready high in IDLE)
//   in_features          feature k at [k*FEAT_W +: FEAT_W]
//   mem_req/mem_addr     one-cycle node read request
//   mem_rvalid, mem_*    node response (variable latency)
//   out_valid/out_ready  result handshake, fields held while out_valid
//   out_class/out_attack predicted class, class == ATTACK_CLASS
//   out_err              0 ok, 1 depth, 2 bad feature index, 3 mem timeout
//   out_leaf_node        leaf reached, or node where the error occurred
//   out_depth            internal nodes traversed
//   busy, state_dbg      status / current state
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | waiting for in_valid, in_ready high
// FETCH  | one-cycle mem_req for the current node
// WAIT   | waiting for mem_rvalid, counting toward MEM_TIMEOUT
// EVAL   | depth check, feature compare, step to left/right child
// RESULT | out_valid high until out_ready
module dt_engine_param
  import dt_pkg::*;
#(
  parameter int NUM_FEATURES = 3,
  parameter int FEAT_W       = 64,
  parameter int ADDR_W       = 9,
  parameter int CLASS_W      = 2,
  parameter int MAX_DEPTH    = 20,
  parameter int ATTACK_CLASS = 1,
  parameter int MEM_TIMEOUT  = 15,
  localparam int FIDX_W  = (NUM_FEATURES > 2) ? $clog2(NUM_FEATURES) : 1,
  localparam int DEPTH_W = $clog2(MAX_DEPTH + 1)
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [NUM_FEATURES*FEAT_W-1:0] in_features,
  output logic                           mem_req,
  output logic [ADDR_W-1:0]              mem_addr,
  input  logic                           mem_rvalid,
  input  logic [FIDX_W-1:0]              mem_feature_idx,
  input  logic [FEAT_W-1:0]              mem_threshold,
  input  logic [ADDR_W-1:0]              mem_left_child,
  input  logic [ADDR_W-1:0]              mem_right_child,
  input  logic [CLASS_W-1:0]             mem_prediction,
  input  logic                           mem_is_leaf,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [CLASS_W-1:0]             out_class,
  output logic                           out_attack,
  output logic [1:0]                     out_err,
  output logic [ADDR_W-1:0]              out_leaf_node,
  output logic [DEPTH_W-1:0]             out_depth,
  output logic                           busy,
  output logic [2:0]                     state_dbg
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [FIDX_W:0]    NF_L     = NUM_FEATURES[FIDX_W:0];
  localparam logic [DEPTH_W-1:0] DEPTH_L  = DEPTH_W'(MAX_DEPTH);
  localparam logic [TMO_W-1:0]   TMO_L    = TMO_W'(MEM_TIMEOUT);
  localparam logic [CLASS_W-1:0] ATTACK_L = CLASS_W'(ATTACK_CLASS);

  dt_state_e                     state_q, state_d;
  logic [NUM_FEATURES*FEAT_W-1:0] feat_q, feat_d;
  logic [ADDR_W-1:0]             node_q, node_d;
  logic [ADDR_W-1:0]             addr_q, addr_d;
  logic [DEPTH_W-1:0]            depth_q, depth_d;
  logic [TMO_W-1:0]              wcnt_q, wcnt_d;
  logic [FIDX_W-1:0]             fidx_q, fidx_d;
  logic [FEAT_W-1:0]             thr_q, thr_d;
  logic [ADDR_W-1:0]             left_q, left_d;
  logic [ADDR_W-1:0]             right_q, right_d;
  logic [CLASS_W-1:0]            class_q, class_d;
  logic                          attack_q, attack_d;
  logic [1:0]                    err_q, err_d;

  logic [FIDX_W-1:0] sel_idx;
  logic [FEAT_W-1:0] feat_sel;
  logic              go_left;

  // fidx_q is only range-checked in WAIT; clamp so the part-select below
  // never leaves the vector when fidx_q holds a stale out-of-range value.
  assign sel_idx  = ({1'b0, fidx_q} < NF_L) ? fidx_q : '0;
  assign feat_sel = feat_q[int'(sel_idx)*FEAT_W +: FEAT_W];

  dt_signed_le_cmp #(.W(FEAT_W)) u_cmp (
    .a_i  (feat_sel),
    .b_i  (thr_q),
    .le_o (go_left)
  );

  always_comb begin
    state_d  = state_q;
    feat_d   = feat_q;
    node_d   = node_q;
    addr_d   = addr_q;
    depth_d  = depth_q;
    wcnt_d   = wcnt_q;
    fidx_d   = fidx_q;
    thr_d    = thr_q;
    left_d   = left_q;
    right_d  = right_q;
    class_d  = class_q;
    attack_d = attack_q;
    err_d    = err_q;

    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          feat_d   = in_features;
          node_d   = '0;
          depth_d  = '0;
          class_d  = '0;
          attack_d = 1'b0;
          err_d    = DT_ERR_NONE;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        addr_d  = node_q;
        wcnt_d  = '0;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_rvalid) begin
          fidx_d  = mem_feature_idx;
          thr_d   = mem_threshold;
          left_d  = mem_left_child;
          right_d = mem_right_child;
          if (mem_is_leaf) begin
            class_d  = mem_prediction;
            attack_d = (mem_prediction == ATTACK_L);
            err_d    = DT_ERR_NONE;
            state_d  = ST_RESULT;
          end else if ({1'b0, mem_feature_idx} >= NF_L) begin
            err_d   = DT_ERR_FIDX;
            state_d = ST_RESULT;
          end else begin
            state_d = ST_EVAL;
          end
        end else begin
          wcnt_d = wcnt_q + 1'b1;
          if (wcnt_d == TMO_L) begin
            err_d   = DT_ERR_TIMEOUT;
            state_d = ST_RESULT;
          end
        end
      end
      ST_EVAL: begin
        if (depth_q == DEPTH_L) begin
          err_d   = DT_ERR_DEPTH;
          state_d = ST_RESULT;
        end else begin
          node_d  = go_left ? left_q : right_q;
          depth_d = depth_q + 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_RESULT: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      feat_q   <= '0;
      node_q   <= '0;
      addr_q   <= '0;
      depth_q  <= '0;
      wcnt_q   <= '0;
      fidx_q   <= '0;
      thr_q    <= '0;
      left_q   <= '0;
      right_q  <= '0;
      class_q  <= '0;
      attack_q <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      feat_q   <= feat_d;
      node_q   <= node_d;
      addr_q   <= addr_d;
      depth_q  <= depth_d;
      wcnt_q   <= wcnt_d;
      fidx_q   <= fidx_d;
      thr_q    <= thr_d;
      left_q   <= left_d;
      right_q  <= right_d;
      class_q  <= class_d;
      attack_q <= attack_d;
      err_q    <= err_d;
    end
  end

  // mem_addr shows the node during FETCH and then holds it, even though
  // node_q moves on in EVAL.
  assign mem_req       = (state_q == ST_FETCH);
  assign mem_addr      = (state_q == ST_FETCH) ? node_q : addr_q;
  assign in_ready      = (state_q == ST_IDLE);
  assign out_valid     = (state_q == ST_RESULT);
  assign busy          = (state_q != ST_IDLE);
  assign state_dbg     = state_q;
  assign out_class     = class_q;
  assign out_attack    = attack_q;
  assign out_err       = err_q;
  assign out_leaf_node = node_q;
  assign out_depth     = depth_q;

endmodule
